// File: rtl/delay_handshake_pkg.sv
// Shared definitions for the elastic delay line.
package Delay_pkg;

    // Width of the occupancy counter: enough to hold 0..delay.
    function automatic int unsigned count_width(input int unsigned delay);
        return $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/delay_handshake_if.sv
// Producer/consumer handshake bundle for delay_handshake.
interface delay_handshake_if
    import Delay_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DELAY = 2
);
    localparam int unsigned CountW = count_width(DELAY);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out;
    logic [CountW-1:0] count;

    // Environment side: producer, consumer and flush control.
    modport master (
        output flush, in_valid, in, out_ready,
        input  in_ready, out_valid, out, count
    );

    // Delay line side.
    modport slave (
        input  flush, in_valid, in, out_ready,
        output in_ready, out_valid, out, count
    );
endinterface

// File: rtl/delay_handshake_stage.sv
// One slot of the elastic delay line: registered valid bit and payload.
module delay_handshake_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             move_in,   // upstream item enters this cycle
    input  logic [WIDTH-1:0] data_in,
    input  logic             move_out,  // downstream can take this slot's item
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready_up
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t stage_q, stage_d;

    // Slot can accept when empty or when its current item is leaving.
    always_comb begin
        ready_up = ~stage_q.valid | move_out;
    end

    // Next slot contents: refill or empty when moving, otherwise hold; flush drops valid only.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d.valid = 1'b0;
        end else if (ready_up) begin
            stage_d.valid = move_in;
            if (move_in) begin
                stage_d.data = data_in;
            end
        end
    end

    // Slot register; reset clears payload as well so out reads 0 afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid = stage_q.valid;
    assign data  = stage_q.data;
endmodule

// File: rtl/delay_handshake.sv
// Elastic DELAY-stage pipeline delay with valid/ready on both ends.
module delay_handshake
    import Delay_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DELAY = 2
) (
    input  logic              clock,
    input  logic              reset,
    delay_handshake_if.slave  bus
);
    localparam int unsigned CountW = count_width(DELAY);

    logic             valid    [DELAY];
    logic [WIDTH-1:0] data     [DELAY];
    logic             ready_up [DELAY];
    logic             move_in  [DELAY];
    logic [WIDTH-1:0] data_in  [DELAY];
    logic             move_out [DELAY];

    logic              in_xfer;
    logic              out_xfer;
    logic [CountW-1:0] count_q, count_d;

    // Ready chain runs combinationally from out_ready back to in_ready.
    always_comb begin
        for (int i = 0; i < DELAY; i++) begin
            if (i == DELAY - 1) begin
                move_out[i] = bus.out_ready;
            end else begin
                move_out[i] = ready_up[i + 1];
            end
            if (i == 0) begin
                move_in[i] = in_xfer;
                data_in[i] = bus.in;
            end else begin
                move_in[i] = valid[i - 1];
                data_in[i] = data[i - 1];
            end
        end
    end

    for (genvar g = 0; g < DELAY; g++) begin : g_stage
        delay_handshake_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .flush    (bus.flush),
            .move_in  (move_in[g]),
            .data_in  (data_in[g]),
            .move_out (move_out[g]),
            .valid    (valid[g]),
            .data     (data[g]),
            .ready_up (ready_up[g])
        );
    end

    // Handshake outputs; flush and reset block every transfer.
    always_comb begin
        bus.in_ready  = ready_up[0] & ~bus.flush & reset;
        bus.out_valid = valid[DELAY-1] & ~bus.flush;
        bus.out       = data[DELAY-1];
        in_xfer       = bus.in_valid & bus.in_ready;
        out_xfer      = bus.out_valid & bus.out_ready;
    end

    // Occupancy bookkeeping.
    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + 1'b1;
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - 1'b1;
        end
    end

    // Occupancy register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;
endmodule

// File: tb/tb_delay_handshake.sv
// Directed self-checking bench for delay_handshake (WIDTH=4, DELAY=2).
module tb_delay_handshake;
    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;

    delay_handshake_if #(.WIDTH(4), .DELAY(2)) bus ();

    delay_handshake #(
        .WIDTH (4),
        .DELAY (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 4'h5;
        bus.out_ready = 1'b1;
        repeat (2) step();
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out !== 4'h0 || bus.count !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b out=%h cnt=%0d expected 0 0 0",
                     bus.out_valid, bus.out, bus.count);
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_streaming();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = (k < 8);
            bus.in       = 4'(k);
            #1;
            if (k < 8) begin
                tests_run++;
                if (bus.in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, bus.in_ready);
                end
            end
            tests_run++;
            if (k < 2) begin
                if (bus.out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stream_early_valid[%0d]: got %b expected 0", k, bus.out_valid);
                end
            end else if (bus.out_valid !== 1'b1 || bus.out !== 4'(k - 2)) begin
                tests_failed++;
                $display("FAIL stream_out[%0d]: got v=%b out=%h expected v=1 out=%h",
                         k, bus.out_valid, bus.out, 4'(k - 2));
            end
            step();
        end
        drain();
    endtask

    task automatic test_backpressure();
        int exp_out;
        int next_in;
        exp_out = 0;
        next_in = 0;
        for (int c = 0; c < 30 && exp_out < 6; c++) begin
            bus.in_valid  = (next_in <= 5);
            bus.in        = 4'(next_in);
            bus.out_ready = !(c >= 3 && c <= 5);
            #1;
            if (c >= 3 && c <= 5) begin
                tests_run++;
                if (bus.count !== 2'd2 || bus.in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_full[%0d]: got cnt=%0d rdy=%b expected cnt=2 rdy=0",
                             c, bus.count, bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                tests_run++;
                if (bus.out !== 4'(exp_out)) begin
                    tests_failed++;
                    $display("FAIL bp_order: got %h expected %h", bus.out, 4'(exp_out));
                end
                exp_out++;
            end
            if (bus.in_valid && bus.in_ready) next_in++;
            step();
        end
        tests_run++;
        if (exp_out != 6) begin
            tests_failed++;
            $display("FAIL bp_timeout: got %0d items expected 6", exp_out);
        end
        bus.in_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_extra_item: got valid=%b expected 0", bus.out_valid);
        end
        drain();
    endtask

    task automatic test_full_passthrough();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 4'hA;
        step();
        bus.in        = 4'hB;
        step();
        bus.out_ready = 1'b1;
        bus.in        = 4'hC;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out !== 4'hA ||
            bus.count !== 2'd2) begin
            tests_failed++;
            $display("FAIL full_pass: got rdy=%b v=%b out=%h cnt=%0d expected 1 1 a 2",
                     bus.in_ready, bus.out_valid, bus.out, bus.count);
        end
        step();
        bus.in_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.count !== 2'd2 || bus.out !== 4'hB) begin
            tests_failed++;
            $display("FAIL full_pass_after: got cnt=%0d out=%h expected 2 b", bus.count, bus.out);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out !== 4'hC || bus.count !== 2'd1) begin
            tests_failed++;
            $display("FAIL full_pass_last: got v=%b out=%h cnt=%0d expected 1 c 1",
                     bus.out_valid, bus.out, bus.count);
        end
        drain();
    endtask

    task automatic test_bubble_collapse();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 4'h7;
        step();
        bus.in_valid  = 1'b0;
        step();
        bus.in_valid  = 1'b1;
        bus.in        = 4'h8;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bubble_absorb: got rdy=%b expected 1", bus.in_ready);
        end
        step();
        bus.in_valid  = 1'b0;
        step();
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out !== 4'h7) begin
            tests_failed++;
            $display("FAIL bubble_first: got v=%b out=%h expected 1 7", bus.out_valid, bus.out);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out !== 4'h8) begin
            tests_failed++;
            $display("FAIL bubble_second: got v=%b out=%h expected 1 8", bus.out_valid, bus.out);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_empty: got v=%b expected 0", bus.out_valid);
        end
        drain();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 4'h1;
        step();
        bus.in        = 4'h2;
        step();
        bus.flush     = 1'b1;
        bus.in        = 4'h3;
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_block: got rdy=%b v=%b expected 0 0",
                     bus.in_ready, bus.out_valid);
        end
        step();
        bus.flush    = 1'b0;
        bus.in       = 4'h4;
        #1;
        tests_run++;
        if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_clear: got cnt=%0d v=%b expected 0 0", bus.count, bus.out_valid);
        end
        step();
        bus.in_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_early: got v=%b expected 0", bus.out_valid);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out !== 4'h4) begin
            tests_failed++;
            $display("FAIL flush_new_item: got v=%b out=%h expected 1 4", bus.out_valid, bus.out);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 4'h9;
        step();
        bus.in        = 4'hE;
        step();
        bus.in_valid  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.count !== 2'd0 || bus.out !== 4'h0 ||
            bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got v=%b cnt=%0d out=%h rdy=%b expected 0 0 0 0",
                     bus.out_valid, bus.count, bus.out, bus.in_ready);
        end
        step();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_stale[%0d]: got v=%b rdy=%b expected 0 1",
                         k, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in       = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_passthrough();
        test_bubble_collapse();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
